icache_ctrl_nway: RTL and testbench
===================================

// Module: icache_ctrl_nway
// PURPOSE
//  Parametrised N-way set-associative instruction-cache controller with internal tag/data/valid arrays,
//  burst line refill, victim-cache swap, whole-cache flush and saturating access/miss counters.
//  Sits between the fetch stage (read-only, one outstanding request) and the memory/victim-cache side.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  LINE_WORDS  4   32-bit words per line (power of 2, >=2); OFF_W = log2(LINE_WORDS)+2
//  SETS        64  sets (power of 2); IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W
//  WAYS        2   ways (power of 2, 1..8); WAY_W = max(1,log2(WAYS))
// PORTS
//  clk_i          in   1               clock
//  rst_ni         in   1               reset, asynchronous, active-low
//  cpu_valid_i    in   1               fetch request valid; addr held stable until cpu_ready_o
//  cpu_addr_i     in   ADDR_W          fetch byte address (bits [1:0] ignored)
//  cpu_ready_o    out  1               1-cycle pulse: cpu_data_o valid, request retired
//  cpu_data_o     out  32              fetched word
//  stall_o        out  1               high whenever a valid request is not retired this cycle, or flush busy
//  flush_i        in   1               pulse: invalidate all lines
//  mem_req_o      out  1               line refill request, held until mem_ack_i
//  mem_addr_o     out  ADDR_W          line-aligned refill address (low OFF_W bits zero)
//  mem_ack_i      in   1               request accepted
//  mem_rvalid_i   in   1               refill beat valid, beats in word order 0..LINE_WORDS-1
//  mem_rdata_i    in   32              refill beat data
//  vc_hit_i       in   1               victim cache holds line for cpu_addr_i (combinational, during LOOKUP)
//  vc_line_i      in   32*LINE_WORDS   victim-cache line data
//  evict_valid_o  out  1               1-cycle pulse: a valid line is displaced, push to victim cache
//  evict_addr_o   out  ADDR_W          {old tag, index, OFF_W'0}
//  evict_line_o   out  32*LINE_WORDS   displaced line data
//  no_acc_o       out  32              requests accepted (saturating)
//  no_miss_o      out  32              misses incl. victim hits (saturating)
//  no_hit_o       out  32              no_acc_o - no_miss_o (combinational)
// BEHAVIOUR
//  Reset: state IDLE, all valid bits 0, replacement state 0, counters 0; all outputs 0.
//  States: IDLE, LOOKUP, MISS_REQ, REFILL, FLUSH.
//  IDLE: flush_i -> FLUSH; else cpu_valid_i -> LOOKUP, no_acc_o+1. flush_i has priority.
//  LOOKUP: hit = any way valid & tag match. Hit -> cpu_ready_o=1 same cycle, selected word out,
//   replacement state updated (MRU = hit way), -> IDLE. Hit latency: 2 cycles from cpu_valid_i.
//  LOOKUP miss & vc_hit_i: no_miss_o+1; write vc_line_i into victim way, set valid/tag; if victim way
//   was valid, evict_valid_o=1 with its old line (swap); stay LOOKUP -> hits next cycle.
//  LOOKUP miss & !vc_hit_i: no_miss_o+1, latch victim way, -> MISS_REQ.
//  Victim way: first invalid way (lowest index); if all valid, tree-pLRU per set (WAYS=1: way 0).
//  MISS_REQ: mem_req_o=1, mem_addr_o line-aligned; on mem_ack_i -> REFILL, beat counter 0.
//  REFILL: each mem_rvalid_i stores beat into line buffer, counter+1; on last beat: write buffer+tag
//   to victim way, valid=1, evict_valid_o=1 if old line valid, update pLRU, -> LOOKUP (retires as hit).
//  FLUSH: clear valid of one set per cycle, set counter 0..SETS-1, then IDLE; takes SETS cycles;
//   stall_o=1 throughout; flush_i in other states is latched and serviced on return to IDLE.
//  flush_i during REFILL: refill completes and is installed, then flush invalidates it.
//  Counters saturate at 32'hFFFF_FFFF; no_hit_o never underflows (miss <= acc enforced by saturation
//   of acc first). mem_rvalid_i outside REFILL is ignored.
//  Async reset mid-refill: drop state to IDLE, mem_req_o low immediately; stale beats ignored.
// TESTING
//  Cold miss addr 0x100, 4-beat refill 0xA0..0xA3 -> one mem_req (addr 0x100), ready on word 0=0xA0; acc=1 miss=1
//  Re-fetch 0x104 -> cpu_ready_o 2 cycles after valid, data 0xA1, no mem_req; acc=2 miss=1 hit=1
//  Fill 3 tags into same set (WAYS=2) -> 3rd refill pulses evict_valid_o with LRU way's tag/line
//  Miss with vc_hit_i=1, vc_line_i=0xDEAD.. -> no mem_req, evict swap pulse, ready next cycle with 0xDEAD..
//  flush_i after fills (SETS=64) -> stall_o high 64 cycles, previous hit address now misses
//  rst_ni low during REFILL beat 2 -> outputs 0, counters 0, next fetch misses and refills cleanly

Source files
------------

// File: rtl/icache_ctrl_nway.sv
// icache_ctrl_nway
//   N-way set-associative instruction-cache controller. Tag, data, valid and
//   tree-pLRU state are held internally. A miss first tries the victim cache:
//   on a victim hit the line is swapped in, with no memory traffic. Otherwise
//   the line is fetched from memory as a burst of LINE_WORDS beats. A flush
//   clears the valid bits one set per cycle. Saturating counters track
//   accepted requests and misses.
//
//   State   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | wait for a fetch request or flush (flush wins)
//   LOOKUP  | tag compare; hit retires, miss goes to victim cache or memory
//   MISS_REQ| refill request held on mem_req_o until mem_ack_i
//   REFILL  | collect beats; on the last beat install the line, back to LOOKUP
//   FLUSH   | clear valid bits of one set per cycle for SETS cycles
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   cpu_valid_i/cpu_addr_i         fetch request (address held until ready)
//   cpu_ready_o/cpu_data_o         retire pulse and fetched word
//   stall_o                        request pending and not retired, or flush busy
//   flush_i                        invalidate-all pulse
//   mem_req_o/mem_addr_o/mem_ack_i refill request handshake
//   mem_rvalid_i/mem_rdata_i       refill beats, word order
//   vc_hit_i/vc_line_i             victim-cache lookup result for the request
//   evict_valid_o/addr_o/line_o    displaced line pushed to the victim cache
//   no_acc_o/no_miss_o/no_hit_o    statistics
module icache_ctrl_nway #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cpu_valid_i,
    input  logic [ADDR_W-1:0]          cpu_addr_i,
    output logic                       cpu_ready_o,
    output logic [31:0]                cpu_data_o,
    output logic                       stall_o,
    input  logic                       flush_i,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic                       vc_hit_i,
    input  logic [32*LINE_WORDS-1:0]   vc_line_i,
    output logic                       evict_valid_o,
    output logic [ADDR_W-1:0]          evict_addr_o,
    output logic [32*LINE_WORDS-1:0]   evict_line_o,
    output logic [31:0]                no_acc_o,
    output logic [31:0]                no_miss_o,
    output logic [31:0]                no_hit_o
);

    localparam int WRD_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = WRD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LVL    = $clog2(WAYS);
    localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_FLUSH
    } state_t;

    state_t state;

    logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
    logic [LINE_W-1:0] data_arr [SETS][WAYS];
    logic [WAYS-1:0]   valid_arr[SETS];
    logic [PL_W-1:0]   plru_arr [SETS];

    // Word address of the request in flight (byte offset bits dropped).
    logic [ADDR_W-3:0] req_wa;
    logic [WAY_W-1:0]  vic_way;
    logic [WRD_W-1:0]  beat_cnt;
    logic [LINE_W-1:0] line_buf;
    logic [IDX_W-1:0]  flush_cnt;
    logic              flush_pend;

    logic [WRD_W-1:0]  word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign word = req_wa[WRD_W-1:0];
    assign idx  = req_wa[WRD_W +: IDX_W];
    assign tag  = req_wa[ADDR_W-3 -: TAG_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Tree pLRU: each node bit points toward the less recently used subtree.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
        logic [WAY_W-1:0] way;
        logic [PL_W-1:0]  sh;
        int               node;
        way  = '0;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            sh   = bits >> node;
            way  = (way << 1) | WAY_W'(sh[0]);
            node = 2 * node + 1 + int'(sh[0]);
        end
        return way;
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [PL_W-1:0]  res;
        logic [WAY_W-1:0] sh;
        logic             b;
        int               node;
        res  = bits;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            sh   = way >> (LVL - 1 - l);
            b    = sh[0];
            res  = (res & ~(PL_W'(1) << node)) | (PL_W'(!b) << node);
            node = 2 * node + 1 + int'(b);
        end
        return res;
    endfunction

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             have_inv;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] pick_way;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        have_inv = 1'b0;
        inv_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_arr[idx][WAY_W'(w)] && tag_arr[idx][WAY_W'(w)] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!have_inv && !valid_arr[idx][WAY_W'(w)]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
        end
        pick_way = have_inv ? inv_way : plru_victim(plru_arr[idx]);
    end

    // The final beat goes straight into the array alongside the buffered ones.
    logic [LINE_W-1:0] fill_line;
    always_comb begin
        fill_line                   = line_buf;
        fill_line[LINE_W-1 -: 32]   = mem_rdata_i;
    end

    // Single array write port shared by victim-cache swap and refill install.
    logic              arr_we;
    logic [WAY_W-1:0]  arr_way;
    logic [LINE_W-1:0] arr_line;

    always_comb begin
        arr_we   = 1'b0;
        arr_way  = pick_way;
        arr_line = vc_line_i;
        case (state)
            S_LOOKUP: begin
                if (!hit && vc_hit_i) begin
                    arr_we = 1'b1;
                end
            end
            S_REFILL: begin
                if (mem_rvalid_i && beat_cnt == LAST_BEAT) begin
                    arr_we   = 1'b1;
                    arr_way  = vic_way;
                    arr_line = fill_line;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arr_we) begin
            tag_arr[idx][arr_way]  <= tag;
            data_arr[idx][arr_way] <= arr_line;
        end
    end

    assign stall_o  = (cpu_valid_i && !cpu_ready_o) || (state == S_FLUSH);
    assign no_hit_o = no_acc_o - no_miss_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            req_wa        <= '0;
            vic_way       <= '0;
            beat_cnt      <= '0;
            line_buf      <= '0;
            flush_cnt     <= '0;
            flush_pend    <= 1'b0;
            cpu_ready_o   <= 1'b0;
            cpu_data_o    <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            evict_valid_o <= 1'b0;
            evict_addr_o  <= '0;
            evict_line_o  <= '0;
            no_acc_o      <= '0;
            no_miss_o     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            cpu_ready_o   <= 1'b0;
            evict_valid_o <= 1'b0;

            if (flush_i && state != S_IDLE && state != S_FLUSH) begin
                flush_pend <= 1'b1;
            end

            if (arr_we) begin
                evict_valid_o               <= valid_arr[idx][arr_way];
                evict_addr_o                <= {tag_arr[idx][arr_way], idx, OFF_W'(0)};
                evict_line_o                <= data_arr[idx][arr_way];
                valid_arr[idx][arr_way]     <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (flush_i || flush_pend) begin
                        state      <= S_FLUSH;
                        flush_cnt  <= '0;
                        flush_pend <= 1'b0;
                    end else if (cpu_valid_i && !cpu_ready_o) begin
                        // The ready guard stops a request that was just retired
                        // from being accepted a second time.
                        state  <= S_LOOKUP;
                        req_wa <= cpu_addr_i[ADDR_W-1:2];
                        if (no_acc_o != '1) no_acc_o <= no_acc_o + 32'd1;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        cpu_ready_o   <= 1'b1;
                        cpu_data_o    <= data_arr[idx][hit_way][{word, 5'd0} +: 32];
                        plru_arr[idx] <= plru_touch(plru_arr[idx], hit_way);
                        state         <= S_IDLE;
                    end else begin
                        if (no_miss_o < no_acc_o) no_miss_o <= no_miss_o + 32'd1;
                        // A victim-cache hit is installed this cycle; staying in
                        // LOOKUP lets the next cycle retire it as an ordinary hit.
                        if (!vc_hit_i) begin
                            vic_way    <= pick_way;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= {req_wa[ADDR_W-3:WRD_W], OFF_W'(0)};
                            state      <= S_MISS_REQ;
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_rvalid_i) begin
                        line_buf[{beat_cnt, 5'd0} +: 32] <= mem_rdata_i;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            plru_arr[idx] <= plru_touch(plru_arr[idx], vic_way);
                            state         <= S_LOOKUP;
                        end
                    end
                end
                S_FLUSH: begin
                    valid_arr[flush_cnt] <= '0;
                    flush_cnt            <= flush_cnt + 1'b1;
                    if (flush_cnt == LAST_SET) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
module tb_icache_ctrl_nway;

    localparam int LW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cpu_valid_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0;
    logic          cpu_ready_o;
    logic [31:0]   cpu_data_o;
    logic          stall_o;
    logic          flush_i = 1'b0;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic          vc_hit_i = 1'b0;
    logic [LW*32-1:0] vc_line_i = '0;
    logic          evict_valid_o;
    logic [31:0]   evict_addr_o;
    logic [LW*32-1:0] evict_line_o;
    logic [31:0]   no_acc_o, no_miss_o, no_hit_o;

    icache_ctrl_nway dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cpu_valid_i(cpu_valid_i), .cpu_addr_i(cpu_addr_i),
        .cpu_ready_o(cpu_ready_o), .cpu_data_o(cpu_data_o), .stall_o(stall_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .vc_hit_i(vc_hit_i), .vc_line_i(vc_line_i),
        .evict_valid_o(evict_valid_o), .evict_addr_o(evict_addr_o), .evict_line_o(evict_line_o),
        .no_acc_o(no_acc_o), .no_miss_o(no_miss_o), .no_hit_o(no_hit_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] la, input int w);
        if (la == 32'h100) return 32'hA0 + w;
        return (la ^ 32'h5A5A_0000) + w;
    endfunction

    function automatic logic [LW*32-1:0] mem_line(input logic [31:0] la);
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) l[w*32 +: 32] = mem_word(la, w);
        return l;
    endfunction

    // ---------------- cache model: 64 sets x 2 ways, true LRU ----------------
    bit               mv [64][2];
    logic [21:0]      mt [64][2];
    logic [LW*32-1:0] ml [64][2];
    int               mru[64];
    int               m_acc, m_miss;

    bit               e_mem, e_ev;
    int               e_kind;          // 0 hit, 1 victim-cache swap, 2 memory refill
    logic [31:0]      e_line_addr, e_ev_addr, e_word;
    logic [LW*32-1:0] e_ev_line;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 0; mv[s][1] = 0; mru[s] = 1;
        end
        m_acc = 0; m_miss = 0;
    endtask

    task automatic model_flush();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 0; mv[s][1] = 0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit vc, input logic [LW*32-1:0] vl);
        int s, w, hw, vw;
        logic [21:0] t;
        bit h;
        s = int'(a[9:4]); w = int'(a[3:2]); t = a[31:10];
        m_acc++;
        h = 0; hw = 0; vw = 0;
        for (int i = 0; i < 2; i++) if (mv[s][i] && mt[s][i] == t) begin h = 1; hw = i; end
        e_mem = 0; e_ev = 0;
        e_line_addr = {a[31:4], 4'h0};
        e_kind = h ? 0 : (vc ? 1 : 2);
        if (!h) begin
            m_miss++;
            if (!mv[s][0]) vw = 0;
            else if (!mv[s][1]) vw = 1;
            else vw = 1 - mru[s];
            e_ev      = mv[s][vw];
            e_ev_addr = {mt[s][vw], 6'(s), 4'h0};
            e_ev_line = ml[s][vw];
            mv[s][vw] = 1;
            mt[s][vw] = t;
            ml[s][vw] = vc ? vl : mem_line(e_line_addr);
            e_mem     = !vc;
            hw        = vw;
        end
        mru[s] = hw;
        e_word = ml[s][hw][w*32 +: 32];
    endtask

    // ---------------- memory responder ----------------
    int               mem_reqs = 0;
    int               nbeat = 0;
    bit               beating = 0;
    logic [31:0]      cur_la;
    logic [31:0]      last_mem_addr = '0;

    initial begin
        forever begin
            @(posedge clk_i); #1;
            mem_rvalid_i = 1'b0;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                nbeat = 0;
                beating = 1;
            end else if (!beating && mem_req_o) begin
                mem_ack_i = 1'b1;
                mem_reqs++;
                cur_la = mem_addr_o;
                last_mem_addr = mem_addr_o;
                chk("mem_req_expected", 1'b1, e_mem);
                chk("mem_addr", mem_addr_o, e_line_addr);
            end
            if (beating) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(cur_la, nbeat);
                nbeat++;
                if (nbeat == LW) beating = 0;
            end
        end
    end

    // ---------------- output compare ----------------
    int               n_ready = 0, n_evict = 0;
    logic [31:0]      last_data = '0, last_ev_addr = '0;
    logic [LW*32-1:0] last_ev_line = '0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (cpu_ready_o) begin
                n_ready++;
                last_data = cpu_data_o;
                chk("ready_data", cpu_data_o, e_word);
                chk("acc_count", no_acc_o, m_acc);
                chk("miss_count", no_miss_o, m_miss);
                chk("hit_count", no_hit_o, m_acc - m_miss);
            end
            if (evict_valid_o) begin
                n_evict++;
                last_ev_addr = evict_addr_o;
                last_ev_line = evict_line_o;
                chk("evict_expected", 1'b1, e_ev);
                chk("evict_addr", evict_addr_o, e_ev_addr);
                chk("evict_line", evict_line_o, e_ev_line);
            end
        end
    end

    // ---------------- fetch driver ----------------
    task automatic fetch(input logic [31:0] a, input bit vc, input logic [LW*32-1:0] vl);
        int r0, ev0, lat;
        bit got;
        model_access(a, vc, vl);
        r0 = mem_reqs; ev0 = n_evict;
        cpu_addr_i = a; cpu_valid_i = 1'b1; vc_hit_i = vc; vc_line_i = vl;
        lat = 0; got = 0;
        while (!got && lat < 300) begin
            @(posedge clk_i); #1;
            lat++;
            if (cpu_ready_o) got = 1;
            else chk("stall_pending", stall_o, 1'b1);
        end
        cpu_valid_i = 1'b0; vc_hit_i = 1'b0;
        chk("fetch_retired", got, 1'b1);
        if (e_kind == 0) chk("hit_latency", lat, 2);
        if (e_kind == 1) chk("vc_latency", lat, 3);
        @(posedge clk_i); #1;
        chk("mem_req_count", mem_reqs - r0, e_mem ? 1 : 0);
        chk("evict_count", n_evict - ev0, e_ev ? 1 : 0);
    endtask

    task automatic wait_stall_clear(input string nm);
        int k;
        k = 0;
        while (stall_o && k < 300) begin
            @(posedge clk_i); #1;
            k++;
        end
        chk(nm, stall_o, 1'b0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [LW*32-1:0] vl;
        model_reset();
        #3;
        chk("rst_ready", cpu_ready_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_evict", evict_valid_o, 1'b0);
        chk("rst_acc", no_acc_o, 0);
        chk("rst_miss", no_miss_o, 0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_data", cpu_data_o, 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // cold miss, then hit in the same line
        fetch(32'h100, 0, '0);
        chk("cold_data", last_data, 32'hA0);
        chk("cold_mem_addr", last_mem_addr, 32'h100);
        chk("cold_acc", no_acc_o, 1);
        chk("cold_miss", no_miss_o, 1);
        fetch(32'h104, 0, '0);
        chk("hit_data", last_data, 32'hA1);
        chk("hit_acc", no_acc_o, 2);
        chk("hit_miss", no_miss_o, 1);
        chk("hit_hit", no_hit_o, 1);

        // three tags into set 0x10: third refill evicts the LRU line (0x100)
        fetch(32'h500, 0, '0);
        fetch(32'h908, 0, '0);
        chk("lru_evict_addr", last_ev_addr, 32'h100);
        chk("lru_evict_line", last_ev_line, 128'h000000A3_000000A2_000000A1_000000A0);

        // victim-cache swap into the same set: displaces 0x500
        vl = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
        fetch(32'hD00, 1, vl);
        chk("vc_data", last_data, 32'hDEAD0000);
        chk("vc_evict_addr", last_ev_addr, 32'h500);
        fetch(32'hD04, 0, '0);
        chk("vc_hit_data", last_data, 32'hDEAD0001);

        // whole-cache flush
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        cnt = 0;
        while (stall_o && cnt < 500) begin
            cnt++;
            @(posedge clk_i); #1;
        end
        chk("flush_stall_cycles", cnt, 64);
        model_flush();
        fetch(32'hD04, 0, '0);
        chk("post_flush_mem_addr", last_mem_addr, 32'hD00);

        // flush arriving during a refill: line installed and retired, then flushed
        fork
            fetch(32'h2000, 0, '0);
            begin
                int k;
                k = 0;
                while (!mem_rvalid_i && k < 100) begin
                    @(posedge clk_i); #2;
                    k++;
                end
                flush_i = 1'b1;
                @(posedge clk_i); #2;
                flush_i = 1'b0;
            end
        join
        model_flush();
        wait_stall_clear("flush_after_refill_done");
        fetch(32'h2000, 0, '0);
        chk("refill_after_flush_mem_addr", last_mem_addr, 32'h2000);

        // async reset during beat 2 of a refill
        model_access(32'h3040, 0, '0);
        cpu_addr_i = 32'h3040; cpu_valid_i = 1'b1;
        cnt = 0;
        while (!(mem_rvalid_i && nbeat == 3) && cnt < 100) begin
            @(posedge clk_i); #2;
            cnt++;
        end
        chk("reached_beat2", nbeat, 3);
        rst_ni = 1'b0;
        cpu_valid_i = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req_o, 1'b0);
        chk("mid_rst_ready", cpu_ready_o, 1'b0);
        chk("mid_rst_acc", no_acc_o, 0);
        chk("mid_rst_miss", no_miss_o, 0);
        chk("mid_rst_hit", no_hit_o, 0);
        chk("mid_rst_evict", evict_valid_o, 1'b0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        fetch(32'h3044, 0, '0);
        chk("post_rst_mem_addr", last_mem_addr, 32'h3040);
        chk("post_rst_acc", no_acc_o, 1);
        chk("post_rst_miss", no_miss_o, 1);
        fetch(32'h3048, 0, '0);
        chk("post_rst_hit", no_hit_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
